// File: rtl/sdi_mode_detect.sv
// sdi_mode_detect: finds EAV timing references in a 10-bit SDI word stream,
// measures the line length in valid words and reports a debounced video mode
// so the downstream pixel-clock divider only re-phases on a real format change.
module sdi_mode_detect #(
    parameter int          LEN0       = 4400,
    parameter int          LEN1       = 3300,
    parameter int          TOL        = 4,
    parameter int          LOCK_CNT   = 8,
    parameter int          UNLOCK_CNT = 4,
    parameter logic [15:0] MAX_LEN    = 16'hFFF0
) (
    input  logic        sys_clk,
    input  logic        n_rst,
    input  logic [9:0]  data_i,
    input  logic        valid_i,
    output logic        mode_o,
    output logic        locked_o,
    output logic [15:0] line_len_o,
    output logic        len_stb_o
);

    localparam logic [15:0] LEN0_W   = 16'(LEN0);
    localparam logic [15:0] LEN1_W   = 16'(LEN1);
    localparam logic [15:0] TOL_W    = 16'(TOL);
    localparam int          RUN_W    = $clog2(LOCK_CNT + 1);
    localparam int          MISS_W   = $clog2(UNLOCK_CNT + 1);
    localparam logic [RUN_W-1:0]  RUN_MAX  = RUN_W'(LOCK_CNT);
    localparam logic [MISS_W-1:0] MISS_MAX = MISS_W'(UNLOCK_CNT);

    typedef enum logic [1:0] {P_IDLE, P1, P2, P3} parse_t;
    typedef enum logic [1:0] {CLS_NONE, CLS_MATCH0, CLS_MATCH1} cls_t;
    typedef enum logic {SEARCH, LOCKED} state_t;

    parse_t             parse_q, parse_d;
    logic               eav_hit;
    logic [15:0]        cnt_q, cnt_d;
    logic               have_ref_q, have_ref_d;
    logic               ev_q, ev_d;
    logic               ev_meas_q, ev_meas_d;
    logic [15:0]        ev_len_q, ev_len_d;
    logic               ev2_q, ev2_d;
    cls_t               cls_q, cls_d;
    logic [15:0]        line_len_q, line_len_d;
    logic               len_stb_q, len_stb_d;
    logic [15:0]        diff0, diff1;
    cls_t               cand_q, cand_d;
    logic [RUN_W-1:0]   run_q, run_d;
    logic [MISS_W-1:0]  miss_q, miss_d;
    state_t             state_q, state_d;
    logic               mode_q, mode_d;
    cls_t               mode_cls;

    // TRS parser: tracks 3FF 000 000 and flags an EAV on the following XYZ word
    always_comb begin
        parse_d = parse_q;
        eav_hit = 1'b0;
        if (valid_i) begin
            case (parse_q)
                P_IDLE: parse_d = (data_i == 10'h3FF) ? P1 : P_IDLE;
                P1: begin
                    if (data_i == 10'h000)      parse_d = P2;
                    else if (data_i == 10'h3FF) parse_d = P1;
                    else                        parse_d = P_IDLE;
                end
                P2: begin
                    if (data_i == 10'h000)      parse_d = P3;
                    else if (data_i == 10'h3FF) parse_d = P1;
                    else                        parse_d = P_IDLE;
                end
                P3: begin
                    parse_d = P_IDLE;
                    eav_hit = data_i[9] & data_i[6];
                end
                default: parse_d = P_IDLE;
            endcase
        end
    end

    // Line-length counter; raises a measurement event on EAV or a one-shot timeout event
    always_comb begin
        cnt_d      = cnt_q;
        have_ref_d = have_ref_q;
        ev_d       = 1'b0;
        ev_meas_d  = 1'b0;
        ev_len_d   = ev_len_q;
        if (valid_i) begin
            if (eav_hit) begin
                cnt_d      = 16'd1;
                have_ref_d = 1'b1;
                if (have_ref_q) begin
                    ev_d      = 1'b1;
                    ev_meas_d = 1'b1;
                    ev_len_d  = cnt_q;
                end
            end else begin
                if (cnt_q != MAX_LEN) cnt_d = cnt_q + 16'd1;
                if (have_ref_q && (cnt_d == MAX_LEN)) begin
                    ev_d       = 1'b1;
                    have_ref_d = 1'b0;
                end
            end
        end
    end

    // Publish the measured length with a strobe and classify it against both formats
    always_comb begin
        ev2_d      = ev_q;
        len_stb_d  = ev_q & ev_meas_q;
        line_len_d = len_stb_d ? ev_len_q : line_len_q;
        diff0      = (ev_len_q >= LEN0_W) ? (ev_len_q - LEN0_W) : (LEN0_W - ev_len_q);
        diff1      = (ev_len_q >= LEN1_W) ? (ev_len_q - LEN1_W) : (LEN1_W - ev_len_q);
        cls_d      = CLS_NONE;
        if (ev_meas_q) begin
            if (diff0 <= TOL_W)      cls_d = CLS_MATCH0;
            else if (diff1 <= TOL_W) cls_d = CLS_MATCH1;
        end
    end

    // Candidate run tracking and lock/unlock hysteresis; mode only moves on a fresh lock
    always_comb begin
        cand_d   = cand_q;
        run_d    = run_q;
        miss_d   = miss_q;
        state_d  = state_q;
        mode_d   = mode_q;
        mode_cls = mode_q ? CLS_MATCH1 : CLS_MATCH0;
        if (ev2_q) begin
            if ((cls_q == cand_q) && (cls_q != CLS_NONE)) begin
                if (run_q != RUN_MAX) run_d = run_q + 1'b1;
            end else begin
                cand_d = cls_q;
                run_d  = (cls_q == CLS_NONE) ? '0 : RUN_W'(1);
            end
            case (state_q)
                SEARCH: begin
                    if (run_d == RUN_MAX) begin
                        state_d = LOCKED;
                        mode_d  = (cand_d == CLS_MATCH1);
                        miss_d  = '0;
                    end
                end
                LOCKED: begin
                    if (cls_q == mode_cls) begin
                        miss_d = '0;
                    end else begin
                        miss_d = miss_q + 1'b1;
                        if (miss_d == MISS_MAX) begin
                            state_d = SEARCH;
                            run_d   = '0;
                            cand_d  = CLS_NONE;
                            miss_d  = '0;
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // All state registers; synchronous active-low reset discards any partial measurement
    always_ff @(posedge sys_clk) begin
        if (!n_rst) begin
            parse_q    <= P_IDLE;
            cnt_q      <= '0;
            have_ref_q <= 1'b0;
            ev_q       <= 1'b0;
            ev_meas_q  <= 1'b0;
            ev_len_q   <= '0;
            ev2_q      <= 1'b0;
            cls_q      <= CLS_NONE;
            line_len_q <= '0;
            len_stb_q  <= 1'b0;
            cand_q     <= CLS_NONE;
            run_q      <= '0;
            miss_q     <= '0;
            state_q    <= SEARCH;
            mode_q     <= 1'b0;
        end else begin
            parse_q    <= parse_d;
            cnt_q      <= cnt_d;
            have_ref_q <= have_ref_d;
            ev_q       <= ev_d;
            ev_meas_q  <= ev_meas_d;
            ev_len_q   <= ev_len_d;
            ev2_q      <= ev2_d;
            cls_q      <= cls_d;
            line_len_q <= line_len_d;
            len_stb_q  <= len_stb_d;
            cand_q     <= cand_d;
            run_q      <= run_d;
            miss_q     <= miss_d;
            state_q    <= state_d;
            mode_q     <= mode_d;
        end
    end

    assign mode_o     = mode_q;
    assign locked_o   = (state_q == LOCKED);
    assign line_len_o = line_len_q;
    assign len_stb_o  = len_stb_q;

endmodule
